axil_cmd_master: RTL and testbench
==================================

# axil_cmd_master

AXI4-Lite initiator that converts a simple command stream (write/read of one 32-bit register) into single AXI4-Lite transactions and returns each result on a response stream. It drives the AXI-Lite slave port of the register map, so firmware-less sequencers (boot-time init tables, calibration engines) can program RFSoC registers in the `axilite_clk` domain. One transaction is outstanding at a time, with an optional response watchdog.

## Interface
- `ADDR_SEGMENT`, 16'h0000, upper 16 address bits; the full address is {ADDR_SEGMENT, cmd_offset[15:2], 2'b00}
- `TIMEOUT_CYCLES`, 1024, cycles waited for B/R before a timeout is reported (only with the watchdog macro; minimum 2)
- `axilite_clk`  in  1  clock
- `axilite_rst`  in  1  synchronous, active-high reset
- `cmd_valid` / `cmd_ready`  in / out  1  command handshake
- `cmd_write`  in  1  1 = write, 0 = read
- `cmd_offset`  in  16  byte offset; bits [1:0] are ignored
- `cmd_wdata`  in  32  write data
- `cmd_wstrb`  in  4  write byte strobes
- `rsp_valid` / `rsp_ready`  out / in  1  response handshake
- `rsp_rdata`  out  32  read data; 0 for writes
- `rsp_resp`  out  2  BRESP/RRESP captured from the slave
- `rsp_timeout`  out  1  1 = no response within TIMEOUT_CYCLES
- `m_axil`  AXI4Lite.master  —  aw/w/b/ar/r channels, 32-bit address and data; awprot/arprot driven 3'b000

## Operation
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP, DRAIN.
- IDLE: cmd_ready=1. On the handshake, the block registers the address, data, and strobe. It moves to WR_REQ if cmd_write=1, else RD_REQ.
- WR_REQ: awvalid and wvalid assert in the same cycle. Each drops independently on its own ready. Once both handshakes complete (in either order or together), the FSM moves to WR_RESP.
- WR_RESP: bready=1. On bvalid, the block captures bresp and sets rdata to 0, then moves to RSP.
- RD_REQ: arvalid=1 until arready, then RD_RESP. In RD_RESP, rready=1; on rvalid the block captures rdata and rresp, then moves to RSP.
- RSP: rsp_valid=1, with data held stable until rsp_ready, then IDLE. Ready and valid may be high in the same cycle.
- A VALID is never withdrawn before its READY, and no address, data, or strobe changes while VALID is high.
- An error response (SLVERR/DECERR) is only reported, never retried.
- All AXI and response outputs are registered.
- Reset values: cmd_ready=0 during reset and 1 in the first cycle after; all AXI valids, bready, rready, and rsp_valid are 0; rsp_rdata, rsp_resp, and rsp_timeout are 0; state is IDLE.
- Reset mid-transaction aborts immediately. No response is produced, and the downstream bridge must be reset together with this block.

## Timing
- Write, zero-wait slave: accept at cycle 0; aw/w valid at cycle 1 with ready at cycle 1; bready at cycle 2; bvalid at cycle 2; rsp_valid at cycle 3.
- Read, zero-wait slave: arvalid at cycle 1; rready and rvalid at cycle 2; rsp_valid at cycle 3.
- Back-to-back throughput with zero-wait slave and rsp_ready=1: one command per 4 cycles (RSP → IDLE → next accept).
- The watchdog counter clears on entry to WR_RESP/RD_RESP and counts only in those states.
- The request phases (aw/w/ar) have no timeout.

## Configuration
- `AXIL_CMD_MASTER_TIMEOUT_EN` defined:
  - If the counter reaches TIMEOUT_CYCLES in WR_RESP or RD_RESP, the block moves to RSP with rsp_timeout=1, rsp_resp=2'b10, and rsp_rdata=0.
  - After the response handshake, it enters DRAIN instead of IDLE. DRAIN holds bready/rready=1 and cmd_ready=0, discards the late response, then returns to IDLE.
  - If the late response arrives while still in RSP, it is accepted and discarded there, and DRAIN is skipped.
- Not defined: no counter logic; the block waits for B/R indefinitely; rsp_timeout is tied to 0; DRAIN is unreachable.

## Test plan
- Write: offset 16'h0104, data 32'hDEADBEEF, strb 4'hF, ADDR_SEGMENT=16'h0002 -> awaddr 32'h00020104, wdata DEADBEEF, wstrb F; rsp_valid at cycle 3 with resp 2'b00, rdata 0.
- Skewed write handshakes: wready 3 cycles before awready, then the reverse order -> each valid drops exactly on its own ready; exactly one B accepted; one response.
- Read with arready delayed 5 cycles and rvalid delayed 7 cycles, rdata 32'h12345678, rresp 2'b10 -> arvalid stable for 6 cycles; rsp_rdata 12345678, rsp_resp 2'b10.
- Backpressure: rsp_ready held low 10 cycles, then a second command presented -> response stable; cmd_ready=0 until the response handshake; second command accepted one cycle after.
- Timeout (macro on, TIMEOUT_CYCLES=16): slave never asserts bvalid -> rsp_valid with rsp_timeout=1 and resp 2'b10. A later bvalid is consumed in DRAIN and the next command proceeds normally.
- Reset asserted while in RD_RESP -> next cycle: all valids 0, rsp_valid 0, state IDLE, no spurious response.

Source files
------------

// File: rtl/axil_cmd_master_if.sv
// AXI4-Lite bus bundle, 32-bit address and data.
// modport master : drives aw/w/ar requests and bready/rready
// modport slave  : drives awready/wready/arready and the b/r responses
interface axil_cmd_master_if;
   logic [31:0] awaddr;
   logic [2:0]  awprot;
   logic        awvalid;
   logic        awready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wvalid;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;
   logic [31:0] araddr;
   logic [2:0]  arprot;
   logic        arvalid;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready;

   modport master (
      output awaddr, awprot, awvalid, input awready,
      output wdata, wstrb, wvalid, input wready,
      input bresp, bvalid, output bready,
      output araddr, arprot, arvalid, input arready,
      input rdata, rresp, rvalid, output rready
   );

   modport slave (
      input awaddr, awprot, awvalid, output awready,
      input wdata, wstrb, wvalid, output wready,
      output bresp, bvalid, input bready,
      input araddr, arprot, arvalid, output arready,
      output rdata, rresp, rvalid, input rready
   );
endinterface

// File: rtl/axil_cmd_master.sv
// axil_cmd_master: turns a command stream (single 32-bit register write/read)
// into one AXI4-Lite transaction at a time and returns the result on a
// response stream.
// Ports:
//   axilite_clk, axilite_rst  clock, synchronous active-high reset
//   cmd_*                     command stream (valid/ready, write flag,
//                             byte offset, write data, strobes)
//   rsp_*                     response stream (valid/ready, read data,
//                             BRESP/RRESP, timeout flag)
//   m_axil                    AXI4-Lite master port
// Optional feature: define AXIL_CMD_MASTER_TIMEOUT_EN to enable the B/R
// response watchdog (TIMEOUT_CYCLES); without it rsp_timeout is tied to 0.
module axil_cmd_master #(
   parameter logic [15:0] ADDR_SEGMENT   = 16'h0000,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic        axilite_clk,
   input  logic        axilite_rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_write,
   input  logic [15:0] cmd_offset,
   input  logic [31:0] cmd_wdata,
   input  logic [3:0]  cmd_wstrb,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic [1:0]  rsp_resp,
   output logic        rsp_timeout,
   axil_cmd_master_if.master m_axil
);
   // state   | meaning
   // IDLE    | cmd_ready high, waiting for a command
   // WR_REQ  | aw/w valid, each held until its own ready
   // WR_RESP | bready high, waiting for B
   // RD_REQ  | arvalid held until arready
   // RD_RESP | rready high, waiting for R
   // RSP     | rsp_valid held until rsp_ready
   // DRAIN   | swallow a late B/R after a timeout (watchdog build only)
   typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP, DRAIN} state_t;

   if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 2");
   end

   state_t      state;
   logic        cmd_ready_q;
   logic [31:0] addr_q;
   logic        unused_offset_lsbs;

   assign unused_offset_lsbs = ^cmd_offset[1:0];

   // Registered ready is preset during reset; masking keeps it low while
   // reset is held and lets it show 1 in the first cycle afterwards.
   assign cmd_ready     = cmd_ready_q & ~axilite_rst;
   assign m_axil.awaddr = addr_q;
   assign m_axil.araddr = addr_q;
   assign m_axil.awprot = 3'b000;
   assign m_axil.arprot = 3'b000;

`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] wd_cnt;
   logic             late_pending;
   logic             timeout_q;
   logic             late_hit;

   // After a timeout bready/rready stay high only to absorb the late beat.
   assign late_hit    = (m_axil.bready && m_axil.bvalid) || (m_axil.rready && m_axil.rvalid);
   assign rsp_timeout = timeout_q;
`else
   assign rsp_timeout = 1'b0;
`endif

   always_ff @(posedge axilite_clk) begin
      if (axilite_rst) begin
         state          <= IDLE;
         cmd_ready_q    <= 1'b1;
         addr_q         <= '0;
         m_axil.wdata   <= '0;
         m_axil.wstrb   <= '0;
         m_axil.awvalid <= 1'b0;
         m_axil.wvalid  <= 1'b0;
         m_axil.bready  <= 1'b0;
         m_axil.arvalid <= 1'b0;
         m_axil.rready  <= 1'b0;
         rsp_valid      <= 1'b0;
         rsp_rdata      <= '0;
         rsp_resp       <= '0;
`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
         wd_cnt         <= '0;
         late_pending   <= 1'b0;
         timeout_q      <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (cmd_valid && cmd_ready_q) begin
                  cmd_ready_q  <= 1'b0;
                  addr_q       <= {ADDR_SEGMENT, cmd_offset[15:2], 2'b00};
                  m_axil.wdata <= cmd_wdata;
                  m_axil.wstrb <= cmd_wstrb;
                  if (cmd_write) begin
                     m_axil.awvalid <= 1'b1;
                     m_axil.wvalid  <= 1'b1;
                     state          <= WR_REQ;
                  end else begin
                     m_axil.arvalid <= 1'b1;
                     state          <= RD_REQ;
                  end
               end
            end
            WR_REQ: begin
               if (m_axil.awready) m_axil.awvalid <= 1'b0;
               if (m_axil.wready)  m_axil.wvalid  <= 1'b0;
               if ((!m_axil.awvalid || m_axil.awready) && (!m_axil.wvalid || m_axil.wready)) begin
                  m_axil.bready <= 1'b1;
                  state         <= WR_RESP;
`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
                  wd_cnt        <= CNT_LOAD;
`endif
               end
            end
            WR_RESP: begin
               if (m_axil.bvalid) begin
                  m_axil.bready <= 1'b0;
                  rsp_rdata     <= '0;
                  rsp_resp      <= m_axil.bresp;
                  rsp_valid     <= 1'b1;
                  state         <= RSP;
`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
                  timeout_q     <= 1'b0;
               end else if (wd_cnt == '0) begin
                  rsp_rdata     <= '0;
                  rsp_resp      <= 2'b10;
                  rsp_valid     <= 1'b1;
                  timeout_q     <= 1'b1;
                  late_pending  <= 1'b1;
                  state         <= RSP;
               end else begin
                  wd_cnt        <= wd_cnt - 1'b1;
`endif
               end
            end
            RD_REQ: begin
               if (m_axil.arready) begin
                  m_axil.arvalid <= 1'b0;
                  m_axil.rready  <= 1'b1;
                  state          <= RD_RESP;
`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
                  wd_cnt         <= CNT_LOAD;
`endif
               end
            end
            RD_RESP: begin
               if (m_axil.rvalid) begin
                  m_axil.rready <= 1'b0;
                  rsp_rdata     <= m_axil.rdata;
                  rsp_resp      <= m_axil.rresp;
                  rsp_valid     <= 1'b1;
                  state         <= RSP;
`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
                  timeout_q     <= 1'b0;
               end else if (wd_cnt == '0) begin
                  rsp_rdata     <= '0;
                  rsp_resp      <= 2'b10;
                  rsp_valid     <= 1'b1;
                  timeout_q     <= 1'b1;
                  late_pending  <= 1'b1;
                  state         <= RSP;
               end else begin
                  wd_cnt        <= wd_cnt - 1'b1;
`endif
               end
            end
            RSP: begin
`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
               if (late_pending && late_hit) begin
                  late_pending  <= 1'b0;
                  m_axil.bready <= 1'b0;
                  m_axil.rready <= 1'b0;
               end
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  if (late_pending && !late_hit) begin
                     state <= DRAIN;
                  end else begin
                     cmd_ready_q <= 1'b1;
                     state       <= IDLE;
                  end
               end
`else
               if (rsp_ready) begin
                  rsp_valid   <= 1'b0;
                  cmd_ready_q <= 1'b1;
                  state       <= IDLE;
               end
`endif
            end
            DRAIN: begin
`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
               if (late_hit) begin
                  late_pending  <= 1'b0;
                  m_axil.bready <= 1'b0;
                  m_axil.rready <= 1'b0;
                  cmd_ready_q   <= 1'b1;
                  state         <= IDLE;
               end
`else
               cmd_ready_q <= 1'b1;
               state       <= IDLE;
`endif
            end
            default: begin
               cmd_ready_q <= 1'b1;
               state       <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_axil_cmd_master.sv
// Directed bench for axil_cmd_master with an ADDR_SEGMENT of 16'h0002 and a
// 16-cycle watchdog. The AXI slave side is driven cycle by cycle from the
// main initial block; inputs change and outputs are sampled on the falling
// edge. The watchdog scenario runs only when AXIL_CMD_MASTER_TIMEOUT_EN is set.
module tb_axil_cmd_master;
   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [15:0] cmd_offset;
   logic [31:0] cmd_wdata;
   logic [3:0]  cmd_wstrb;
   logic        rsp_valid, rsp_ready, rsp_timeout;
   logic [31:0] rsp_rdata;
   logic [1:0]  rsp_resp;

   int checks   = 0;
   int failures = 0;
   int b_cnt    = 0;
   int rsp_cnt  = 0;

   always #5 clk = ~clk;

   axil_cmd_master_if axil ();

   axil_cmd_master #(
      .ADDR_SEGMENT   (16'h0002),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .axilite_clk (clk),
      .axilite_rst (rst),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_write   (cmd_write),
      .cmd_offset  (cmd_offset),
      .cmd_wdata   (cmd_wdata),
      .cmd_wstrb   (cmd_wstrb),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_rdata   (rsp_rdata),
      .rsp_resp    (rsp_resp),
      .rsp_timeout (rsp_timeout),
      .m_axil      (axil)
   );

   always @(posedge clk) begin
      if (!rst) begin
         if (axil.bvalid && axil.bready) b_cnt <= b_cnt + 1;
         if (rsp_valid && rsp_ready)     rsp_cnt <= rsp_cnt + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(negedge clk);
   endtask

   // Zero-wait write: accept at cycle 0, aw/w at 1, B at 2, response at 3.
   task automatic wr_zero(input logic [15:0] off, input logic [31:0] d, input logic [3:0] s,
                          input logic [31:0] exp_addr);
      chk("wr_idle_ready", cmd_ready, 1);
      cmd_valid = 1; cmd_write = 1; cmd_offset = off; cmd_wdata = d; cmd_wstrb = s;
      axil.awready = 1; axil.wready = 1; rsp_ready = 1;
      cyc();
      cmd_valid = 0;
      chk("wr_c1_awvalid", axil.awvalid, 1);
      chk("wr_c1_wvalid", axil.wvalid, 1);
      chk("wr_c1_awaddr", axil.awaddr, exp_addr);
      chk("wr_c1_wdata", axil.wdata, d);
      chk("wr_c1_wstrb", axil.wstrb, s);
      chk("wr_c1_awprot", axil.awprot, 0);
      chk("wr_c1_cmd_ready", cmd_ready, 0);
      cyc();
      axil.awready = 0; axil.wready = 0;
      chk("wr_c2_awvalid", axil.awvalid, 0);
      chk("wr_c2_wvalid", axil.wvalid, 0);
      chk("wr_c2_bready", axil.bready, 1);
      axil.bvalid = 1; axil.bresp = 2'b00;
      cyc();
      axil.bvalid = 0;
      chk("wr_c3_rsp_valid", rsp_valid, 1);
      chk("wr_c3_rsp_resp", rsp_resp, 0);
      chk("wr_c3_rsp_rdata", rsp_rdata, 0);
      chk("wr_c3_rsp_timeout", rsp_timeout, 0);
      chk("wr_c3_bready", axil.bready, 0);
      cyc();
      chk("wr_c4_rsp_valid", rsp_valid, 0);
      chk("wr_c4_cmd_ready", cmd_ready, 1);
   endtask

   // One ready arrives at cycle 1, the other three cycles later at cycle 4.
   task automatic wr_skew(input bit aw_first, input logic [31:0] d);
      int b0, r0;
      b0 = b_cnt; r0 = rsp_cnt;
      cmd_valid = 1; cmd_write = 1; cmd_offset = 16'h0208; cmd_wdata = d; cmd_wstrb = 4'h3;
      axil.awready = 0; axil.wready = 0; rsp_ready = 1;
      cyc();
      cmd_valid = 0;
      for (int k = 1; k <= 4; k++) begin
         chk("skew_awvalid", axil.awvalid, aw_first ? (k == 1) : 1);
         chk("skew_wvalid", axil.wvalid, aw_first ? 1 : (k == 1));
         chk("skew_wdata", axil.wdata, d);
         chk("skew_bready", axil.bready, 0);
         axil.awready = aw_first ? (k == 1) : (k == 4);
         axil.wready  = aw_first ? (k == 4) : (k == 1);
         cyc();
      end
      axil.awready = 0; axil.wready = 0;
      chk("skew_done_awvalid", axil.awvalid, 0);
      chk("skew_done_wvalid", axil.wvalid, 0);
      chk("skew_done_bready", axil.bready, 1);
      axil.bvalid = 1; axil.bresp = 2'b11;
      cyc();
      axil.bvalid = 0;
      chk("skew_rsp_valid", rsp_valid, 1);
      chk("skew_rsp_resp", rsp_resp, 2'b11);
      cyc();
      chk("skew_b_count", b_cnt - b0, 1);
      chk("skew_rsp_count", rsp_cnt - r0, 1);
      chk("skew_cmd_ready", cmd_ready, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL global_time_limit got=expired exp=finished");
      $fatal(1, "time limit");
   end

   initial begin
      int r0, n;
      rst = 1; cmd_valid = 0; cmd_write = 0; cmd_offset = 0; cmd_wdata = 0; cmd_wstrb = 0;
      rsp_ready = 0;
      axil.awready = 0; axil.wready = 0; axil.bvalid = 0; axil.bresp = 0;
      axil.arready = 0; axil.rvalid = 0; axil.rdata = 0; axil.rresp = 0;

      // Reset state
      repeat (3) cyc();
      chk("rst_cmd_ready", cmd_ready, 0);
      chk("rst_awvalid", axil.awvalid, 0);
      chk("rst_wvalid", axil.wvalid, 0);
      chk("rst_arvalid", axil.arvalid, 0);
      chk("rst_bready", axil.bready, 0);
      chk("rst_rready", axil.rready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_rdata", rsp_rdata, 0);
      chk("rst_rsp_resp", rsp_resp, 0);
      chk("rst_rsp_timeout", rsp_timeout, 0);
      rst = 0;
      cyc();
      chk("post_rst_cmd_ready", cmd_ready, 1);

      // Zero-wait write
      wr_zero(16'h0104, 32'hDEADBEEF, 4'hF, 32'h00020104);

      // Skewed write handshakes, both orders
      wr_skew(1'b0, 32'h0BAD_F00D);
      wr_skew(1'b1, 32'hCAFE_0001);

      // Read: arready after 5 wait cycles, rvalid at cycle 7, SLVERR; offset LSBs ignored
      cmd_valid = 1; cmd_write = 0; cmd_offset = 16'h0013; rsp_ready = 0;
      cyc();
      cmd_valid = 0;
      for (int k = 1; k <= 6; k++) begin
         chk("rd_arvalid_hold", axil.arvalid, 1);
         chk("rd_araddr", axil.araddr, 32'h00020010);
         chk("rd_rready_low", axil.rready, 0);
         axil.arready = (k == 6);
         cyc();
      end
      axil.arready = 0;
      chk("rd_c7_arvalid", axil.arvalid, 0);
      chk("rd_c7_rready", axil.rready, 1);
      axil.rvalid = 1; axil.rdata = 32'h12345678; axil.rresp = 2'b10;
      cyc();
      axil.rvalid = 0; axil.rdata = 0; axil.rresp = 0;
      chk("rd_rready_drop", axil.rready, 0);

      // Backpressure: response held 10 cycles with a second command waiting
      cmd_valid = 1; cmd_write = 0; cmd_offset = 16'h0020;
      for (int k = 0; k < 10; k++) begin
         chk("bp_rsp_valid", rsp_valid, 1);
         chk("bp_rsp_rdata", rsp_rdata, 32'h12345678);
         chk("bp_rsp_resp", rsp_resp, 2'b10);
         chk("bp_cmd_ready", cmd_ready, 0);
         cyc();
      end
      rsp_ready = 1;
      cyc();
      chk("bp_rsp_done", rsp_valid, 0);
      chk("bp_accept_ready", cmd_ready, 1);
      cyc();
      cmd_valid = 0;
      chk("rd0_c1_arvalid", axil.arvalid, 1);
      chk("rd0_c1_araddr", axil.araddr, 32'h00020020);
      chk("rd0_c1_arprot", axil.arprot, 0);
      axil.arready = 1;
      cyc();
      axil.arready = 0;
      chk("rd0_c2_arvalid", axil.arvalid, 0);
      chk("rd0_c2_rready", axil.rready, 1);
      axil.rvalid = 1; axil.rdata = 32'hA5A50F0F; axil.rresp = 2'b00;
      cyc();
      axil.rvalid = 0; axil.rdata = 0;
      chk("rd0_c3_rsp_valid", rsp_valid, 1);
      chk("rd0_c3_rsp_rdata", rsp_rdata, 32'hA5A50F0F);
      chk("rd0_c3_rsp_resp", rsp_resp, 0);
      cyc();
      chk("rd0_c4_cmd_ready", cmd_ready, 1);

      // Reset while in RD_RESP
      r0 = rsp_cnt;
      cmd_valid = 1; cmd_write = 0; cmd_offset = 16'h0030;
      cyc();
      cmd_valid = 0; axil.arready = 1;
      cyc();
      axil.arready = 0;
      chk("rr_in_rd_resp", axil.rready, 1);
      rst = 1;
      cyc();
      chk("rr_arvalid", axil.arvalid, 0);
      chk("rr_awvalid", axil.awvalid, 0);
      chk("rr_wvalid", axil.wvalid, 0);
      chk("rr_rready", axil.rready, 0);
      chk("rr_rsp_valid", rsp_valid, 0);
      chk("rr_cmd_ready", cmd_ready, 0);
      rst = 0;
      cyc();
      chk("rr_idle_ready", cmd_ready, 1);
      repeat (3) cyc();
      chk("rr_no_rsp_valid", rsp_valid, 0);
      chk("rr_no_rsp_count", rsp_cnt - r0, 0);

`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
      // Watchdog: B never arrives; 16 cycles in WR_RESP (cycles 2..17), response at 18
      cmd_valid = 1; cmd_write = 1; cmd_offset = 16'h0040; cmd_wdata = 32'h1; cmd_wstrb = 4'hF;
      axil.awready = 1; axil.wready = 1; rsp_ready = 1;
      cyc();
      cmd_valid = 0;
      cyc();
      axil.awready = 0; axil.wready = 0;
      chk("to_bready", axil.bready, 1);
      n = 2;
      while (!rsp_valid && n < 60) begin
         cyc();
         n++;
      end
      chk("to_rsp_cycle", n, 18);
      chk("to_rsp_timeout", rsp_timeout, 1);
      chk("to_rsp_resp", rsp_resp, 2'b10);
      chk("to_rsp_rdata", rsp_rdata, 0);
      chk("to_bready_held", axil.bready, 1);
      cyc();
      chk("drain_cmd_ready", cmd_ready, 0);
      chk("drain_bready", axil.bready, 1);
      chk("drain_rsp_valid", rsp_valid, 0);
      axil.bvalid = 1; axil.bresp = 2'b00;
      cyc();
      axil.bvalid = 0;
      chk("drain_done_bready", axil.bready, 0);
      chk("drain_done_cmd_ready", cmd_ready, 1);
      chk("drain_no_extra_rsp", rsp_valid, 0);
      wr_zero(16'h0044, 32'h55AA55AA, 4'h5, 32'h00020044);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
